// File: rtl/structure2_fc1_pkg.sv
// Shared constants and state encoding for the structure-2 FC1 neuron engine.
// Default layer geometry, accumulator/product widths and the FSM state set.
package structure2_fc1_pkg;

    localparam int FC1_IN_LEN  = 192;
    localparam int FC1_OUT_LEN = 128;
    localparam int FC1_ACC_W   = 24;
    localparam int FC1_SHIFT   = 7;
    localparam int FC1_PROD_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MAC      = 3'd1,
        ST_BIAS_REQ = 3'd2,
        ST_BIAS_ADD = 3'd3,
        ST_OUT      = 3'd4
    } fc1_state_e;

endpackage

// File: rtl/structure2_fc1_requant.sv
// Requantizer: (acc >>> SHIFT) + bias, optional ReLU (STRUCTURE2_FC1_RELU_EN), saturate to int8.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the result is valid whenever its inputs are.
module structure2_fc1_requant #(
    parameter int ACC_W = 24,
    parameter int SHIFT = 7
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [7:0]       bias,
    output logic [7:0]       result
);
    localparam int SUM_W = ACC_W - SHIFT + 1;
    localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(127);
    localparam logic signed [SUM_W-1:0] SAT_LO = -SUM_W'(128);

    logic signed [ACC_W-1:0] acc_sh;
    logic signed [SUM_W-1:0] sh_part;
    logic signed [SUM_W-1:0] bias_part;
    logic signed [SUM_W-1:0] sum;

    always_comb begin
        // Arithmetic shift floors toward -inf; the shifted value fits in ACC_W-SHIFT bits.
        acc_sh    = $signed(acc) >>> SHIFT;
        sh_part   = acc_sh[SUM_W-1:0];
        bias_part = {{(SUM_W-8){bias[7]}}, bias};
        sum       = sh_part + bias_part;
        result    = sum[7:0];
`ifdef STRUCTURE2_FC1_RELU_EN
        if (sum < 0) begin
            result = 8'h00;
        end else if (sum > SAT_HI) begin
            result = 8'h7f;
        end
`else
        if (sum > SAT_HI) begin
            result = 8'h7f;
        end else if (sum < SAT_LO) begin
            result = 8'h80;
        end
`endif
    end

endmodule

// File: rtl/structure2_fc1_neuron.sv
// FC1 neuron engine: MAC IN_LEN int8 pairs, fetch bias, requantize, emit OUT_LEN int8 results.
// Latency: result 3 cycles after the last sample; ReLU enabled by STRUCTURE2_FC1_RELU_EN.
// Backpressure: none; the consumer must accept every dout_valid.
module structure2_fc1_neuron
    import structure2_fc1_pkg::*;
#(
    parameter int IN_LEN  = FC1_IN_LEN,
    parameter int OUT_LEN = FC1_OUT_LEN,
    parameter int ACC_W   = FC1_ACC_W,
    parameter int SHIFT   = FC1_SHIFT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       din_valid,
    input  logic [7:0] din,
    input  logic [7:0] w_in,
    output logic       bias_en,
    input  logic [7:0] bias_in,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic [7:0] neuron_idx,
    output logic       busy,
    output logic       done
);
    localparam int CNT_W = $clog2(IN_LEN);
    localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_LEN - 1);
    localparam logic [7:0]       OUT_LAST = 8'(OUT_LEN - 1);

    localparam logic [2:0] S_IDLE     = ST_IDLE;
    localparam logic [2:0] S_MAC      = ST_MAC;
    localparam logic [2:0] S_BIAS_REQ = ST_BIAS_REQ;
    localparam logic [2:0] S_BIAS_ADD = ST_BIAS_ADD;
    localparam logic [2:0] S_OUT      = ST_OUT;

    logic [2:0]              state;
    logic                    armed;
    logic [ACC_W-1:0]        acc;
    logic [CNT_W-1:0]        in_cnt;
    logic [7:0]              out_cnt;
    logic signed [FC1_PROD_W-1:0] din_x;
    logic signed [FC1_PROD_W-1:0] w_x;
    logic signed [FC1_PROD_W-1:0] prod;
    logic [ACC_W-1:0]        prod_ext;
    logic [7:0]              result;

    assign din_x    = {{(FC1_PROD_W-8){din[7]}}, din};
    assign w_x      = {{(FC1_PROD_W-8){w_in[7]}}, w_in};
    assign prod     = din_x * w_x;
    assign prod_ext = {{(ACC_W-FC1_PROD_W){prod[FC1_PROD_W-1]}}, prod};

    structure2_fc1_requant #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .acc    (acc),
        .bias   (bias_in),
        .result (result)
    );

    // armed blocks a start that coincides with reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            armed      <= 1'b0;
            acc        <= '0;
            in_cnt     <= '0;
            out_cnt    <= '0;
            bias_en    <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            neuron_idx <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            armed      <= 1'b1;
            bias_en    <= 1'b0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && armed) begin
                        acc     <= '0;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (din_valid) begin
                        acc <= acc + prod_ext;
                        if (in_cnt == IN_LAST) begin
                            bias_en <= 1'b1;
                            state   <= S_BIAS_REQ;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
                end
                S_BIAS_REQ: state <= S_BIAS_ADD;
                S_BIAS_ADD: begin
                    dout       <= result;
                    dout_valid <= 1'b1;
                    neuron_idx <= out_cnt;
                    done       <= (out_cnt == OUT_LAST);
                    state      <= S_OUT;
                end
                S_OUT: begin
                    if (out_cnt == OUT_LAST) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        out_cnt <= out_cnt + 1'b1;
                        acc     <= '0;
                        in_cnt  <= '0;
                        state   <= S_MAC;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_structure2_fc1_neuron.sv
// Self-checking bench for structure2_fc1_neuron with IN_LEN=4, OUT_LEN=3, SHIFT=2 and a modelled bias reader.
module tb_structure2_fc1_neuron;
    localparam int IN_LEN  = 4;
    localparam int OUT_LEN = 3;
    localparam int ACC_W   = 24;
    localparam int SHIFT   = 2;

`ifdef STRUCTURE2_FC1_RELU_EN
    localparam logic [7:0] EXP_NEG5 = 8'h00;
    localparam logic [7:0] EXP_NEG1 = 8'h00;
`else
    localparam logic [7:0] EXP_NEG5 = 8'hfb;
    localparam logic [7:0] EXP_NEG1 = 8'hff;
`endif

    logic       clk, rst_n, start, din_valid;
    logic [7:0] din, w_in, bias_in, dout, neuron_idx;
    logic       bias_en, dout_valid, busy, done;

    int errors = 0;
    int checks = 0;

    logic [7:0] a [OUT_LEN][IN_LEN];
    logic [7:0] w [OUT_LEN][IN_LEN];
    logic [7:0] bias_rom [OUT_LEN];
    int         baddr;

    logic [7:0] q_dout [$];
    logic [7:0] q_idx  [$];
    int         bias_cnt = 0;
    int         done_cnt = 0;
    int         lat_b [OUT_LEN];
    int         lat_d [OUT_LEN];
    logic       busy_start, busy_end;

    structure2_fc1_neuron #(
        .IN_LEN (IN_LEN), .OUT_LEN (OUT_LEN), .ACC_W (ACC_W), .SHIFT (SHIFT)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .din_valid (din_valid),
        .din (din), .w_in (w_in), .bias_en (bias_en), .bias_in (bias_in),
        .dout (dout), .dout_valid (dout_valid), .neuron_idx (neuron_idx),
        .busy (busy), .done (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bias reader: data one cycle after the enable pulse, address steps per pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baddr   <= 0;
            bias_in <= 8'h00;
        end else if (bias_en) begin
            bias_in <= bias_rom[baddr];
            baddr   <= (baddr == OUT_LEN - 1) ? 0 : baddr + 1;
        end
    end

    always @(negedge clk) begin
        if (dout_valid) begin
            q_dout.push_back(dout);
            q_idx.push_back(neuron_idx);
        end
        if (bias_en) bias_cnt++;
        if (done) done_cnt++;
    end

    function automatic logic [7:0] ref_neuron(input int n);
        int acc, s;
        acc = 0;
        for (int k = 0; k < IN_LEN; k++)
            acc += int'($signed(a[n][k])) * int'($signed(w[n][k]));
        s = (acc >>> SHIFT) + int'($signed(bias_rom[n]));
`ifdef STRUCTURE2_FC1_RELU_EN
        if (s < 0) s = 0;
`endif
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s[7:0];
    endfunction

    task automatic fill_random();
        for (int n = 0; n < OUT_LEN; n++) begin
            for (int k = 0; k < IN_LEN; k++) begin
                a[n][k] = 8'($urandom);
                w[n][k] = 8'($urandom);
            end
            bias_rom[n] = 8'($urandom);
        end
    endtask

    task automatic feed(input int n, input int cnt, input bit gaps);
        for (int k = 0; k < cnt; k++) begin
            if (gaps) begin
                @(negedge clk);
                din_valid = 1'b0; din = 8'($urandom); w_in = 8'($urandom);
            end
            @(negedge clk);
            din_valid = 1'b1; din = a[n][k]; w_in = w[n][k];
        end
    endtask

    // Junk with random valid is driven while waiting; the engine must ignore it.
    task automatic wait_out(input int n);
        int c;
        bit got;
        c = 0; got = 1'b0; lat_b[n] = -1; lat_d[n] = -1;
        while (!got && c < 20) begin
            @(negedge clk);
            c++;
            din_valid = 1'($urandom); din = 8'($urandom); w_in = 8'($urandom);
            if (bias_en && lat_b[n] < 0) lat_b[n] = c;
            if (dout_valid) begin lat_d[n] = c; got = 1'b1; end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wait_out n%0d: no dout_valid after %0d cycles, required within 20", n, c);
        end
    endtask

    task automatic run_pass(input bit gaps);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; din_valid = 1'b0;
        busy_start = busy;
        for (int n = 0; n < OUT_LEN; n++) begin
            feed(n, IN_LEN, gaps);
            wait_out(n);
        end
        @(negedge clk); din_valid = 1'b0;
        busy_end = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; din_valid = 1'b0; din = 8'h00; w_in = 8'h00;
        for (int n = 0; n < OUT_LEN; n++) bias_rom[n] = 8'h00;
        repeat (2) @(negedge clk);
        checks += 6;
        if (dout !== 8'h00)       begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
        if (dout_valid !== 1'b0)  begin errors++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid); end
        if (neuron_idx !== 8'h00) begin errors++; $display("FAIL reset_idx: got %h want 00", neuron_idx); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)        begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        if (bias_en !== 1'b0)     begin errors++; $display("FAIL reset_bias_en: got %b want 0", bias_en); end
        start = 1'b1; rst_n = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL start_at_release: busy %b want 0", busy); end
    endtask

    task automatic test_basic();
        int base, bbase, dbase;
        for (int k = 0; k < IN_LEN; k++) begin
            a[0][k] = 8'd2;   w[0][k] = 8'd3;
            a[1][k] = 8'd127; w[1][k] = 8'd127;
            a[2][k] = 8'hfe;  w[2][k] = 8'd3;
        end
        bias_rom[0] = 8'd5; bias_rom[1] = 8'd0; bias_rom[2] = 8'd1;
        base = q_dout.size(); bbase = bias_cnt; dbase = done_cnt;
        run_pass(1'b0);
        checks += 8;
        if (q_dout.size() != base + 3) begin
            errors++; $display("FAIL basic_count: got %0d results want 3", q_dout.size() - base);
        end else begin
            if (q_dout[base] !== 8'd11)    begin errors++; $display("FAIL basic_dout0: got %h want 0b", q_dout[base]); end
            if (q_dout[base+1] !== 8'd127) begin errors++; $display("FAIL sat_dout1: got %h want 7f", q_dout[base+1]); end
            if (q_dout[base+2] !== EXP_NEG5) begin errors++; $display("FAIL neg_dout2: got %h want %h", q_dout[base+2], EXP_NEG5); end
            if (q_idx[base] !== 8'd0)      begin errors++; $display("FAIL basic_idx0: got %0d want 0", q_idx[base]); end
        end
        if (bias_cnt - bbase != 3) begin errors++; $display("FAIL basic_bias_pulses: got %0d want 3", bias_cnt - bbase); end
        if (done_cnt - dbase != 1) begin errors++; $display("FAIL basic_done: got %0d want 1", done_cnt - dbase); end
        if (lat_b[0] != 1 || lat_d[0] != 3) begin
            errors++; $display("FAIL basic_latency: bias_en at +%0d dout_valid at +%0d, want +1 +3", lat_b[0], lat_d[0]);
        end
        checks += 2;
        if (busy_start !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b want 1", busy_start); end
        if (busy_end !== 1'b0)   begin errors++; $display("FAIL busy_fall: got %b want 0", busy_end); end
    endtask

    task automatic test_truncation();
        int base;
        fill_random();
        a[0][0] = 8'hff; w[0][0] = 8'h01;
        for (int k = 1; k < IN_LEN; k++) begin a[0][k] = 8'h00; w[0][k] = 8'h00; end
        bias_rom[0] = 8'h00;
        base = q_dout.size();
        run_pass(1'b0);
        checks++;
        if (q_dout.size() != base + 3) begin
            errors++; $display("FAIL trunc_count: got %0d results want 3", q_dout.size() - base);
        end else begin
            if (q_dout[base] !== EXP_NEG1) begin errors++; $display("FAIL trunc_dout: got %h want %h", q_dout[base], EXP_NEG1); end
            for (int n = 1; n < OUT_LEN; n++) begin
                checks++;
                if (q_dout[base+n] !== ref_neuron(n)) begin
                    errors++; $display("FAIL trunc_rand n%0d: got %h want %h", n, q_dout[base+n], ref_neuron(n));
                end
            end
        end
    endtask

    task automatic test_gaps();
        int base, bbase, dbase;
        fill_random();
        base = q_dout.size(); bbase = bias_cnt; dbase = done_cnt;
        run_pass(1'b1);
        checks += 3;
        if (q_dout.size() != base + 3) begin
            errors++; $display("FAIL gaps_count: got %0d results want 3", q_dout.size() - base);
        end else begin
            for (int n = 0; n < OUT_LEN; n++) begin
                checks += 2;
                if (q_dout[base+n] !== ref_neuron(n)) begin
                    errors++; $display("FAIL gaps_dout n%0d: got %h want %h", n, q_dout[base+n], ref_neuron(n));
                end
                if (q_idx[base+n] !== 8'(n)) begin
                    errors++; $display("FAIL gaps_idx n%0d: got %0d want %0d", n, q_idx[base+n], n);
                end
            end
        end
        if (bias_cnt - bbase != 3) begin errors++; $display("FAIL gaps_bias_pulses: got %0d want 3", bias_cnt - bbase); end
        if (done_cnt - dbase != 1) begin errors++; $display("FAIL gaps_done: got %0d want 1", done_cnt - dbase); end
    endtask

    task automatic test_back_to_back();
        int base;
        for (int p = 0; p < 4; p++) begin
            fill_random();
            base = q_dout.size();
            run_pass(1'b0);
            checks++;
            if (q_dout.size() != base + 3) begin
                errors++; $display("FAIL b2b_count p%0d: got %0d want 3", p, q_dout.size() - base);
            end else begin
                for (int n = 0; n < OUT_LEN; n++) begin
                    checks++;
                    if (q_dout[base+n] !== ref_neuron(n) || q_idx[base+n] !== 8'(n)) begin
                        errors++;
                        $display("FAIL b2b p%0d n%0d: got %h idx %0d want %h idx %0d",
                                 p, n, q_dout[base+n], q_idx[base+n], ref_neuron(n), n);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        fill_random();
        base = q_dout.size();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; din_valid = 1'b0;
        feed(0, IN_LEN, 1'b0);
        wait_out(0);
        feed(1, 2, 1'b0);
        @(negedge clk); rst_n = 1'b0; din_valid = 1'b0;
        #1;
        checks += 5;
        if (busy !== 1'b0 || dout_valid !== 1'b0 || done !== 1'b0 || bias_en !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl: busy %b dv %b done %b ben %b want 0", busy, dout_valid, done, bias_en);
        end
        if (dout !== 8'h00)       begin errors++; $display("FAIL midrst_dout: got %h want 00", dout); end
        if (neuron_idx !== 8'h00) begin errors++; $display("FAIL midrst_idx: got %h want 00", neuron_idx); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        if (q_dout.size() != base + 1) begin errors++; $display("FAIL midrst_outputs: got %0d results want 1", q_dout.size() - base); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: busy %b want 0", busy); end
        fill_random();
        base = q_dout.size();
        run_pass(1'b0);
        checks++;
        if (q_dout.size() != base + 3) begin
            errors++; $display("FAIL fresh_count: got %0d want 3", q_dout.size() - base);
        end else begin
            for (int n = 0; n < OUT_LEN; n++) begin
                checks++;
                if (q_dout[base+n] !== ref_neuron(n) || q_idx[base+n] !== 8'(n)) begin
                    errors++;
                    $display("FAIL fresh n%0d: got %h idx %0d want %h idx %0d",
                             n, q_dout[base+n], q_idx[base+n], ref_neuron(n), n);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_truncation();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
